alu16_mul_seq: RTL and testbench
================================

// Module: alu16_mul_seq
// PURPOSE
//  Sequencer that computes an unsigned 16x16->32 product.
//  It runs the shared 16-bit ALU through 16 add/right-shift iterations (shift-and-add).
//  Sits between an operand requester (valid/ready handshake) and one alu_16bit instance.
//  It owns that ALU's args, carry_in, carry_disable and cmd inputs for the whole operation.
// PARAMETERS
//  OP_ADD    3'b000  {carry_disable,cmd} encoding driven for ALU ADD
//  OP_RSHFT  3'b111  {carry_disable,cmd} encoding for ALU RSHFT: res = {carry_in, d2[15:1]}
//  ITER      16      iteration count; fixed at 16 to match the 16-bit ALU datapath
// PORTS
//  clk                input   1   single clock, rising edge
//  rst                input   1   asynchronous, active-high reset
//  in_valid           input   1   operands valid
//  in_ready           output  1   block can accept operands (high only in IDLE)
//  in_a               input   16  multiplicand
//  in_b               input   16  multiplier
//  out_valid          output  1   product valid; held until out_ready is high
//  out_ready          input   1   consumer accepts product
//  out_prod           output  32  unsigned product in_a*in_b
//  alu_d1             output  16  to ALU args.d1
//  alu_d2             output  16  to ALU args.d2
//  alu_carry_in       output  1   to ALU carry_in
//  alu_carry_disable  output  1   to ALU carry_disable
//  alu_cmd            output  2   to ALU cmd
//  alu_res            input   16  from ALU res; combinational, same cycle
//  alu_carry_out      input   1   from ALU carry_out
// BEHAVIOUR
//  - Registers
//    - M[15:0]: multiplicand
//    - A[15:0]: accumulator
//    - Q[15:0]: multiplier / product low half
//    - C: add carry
//    - cnt[3:0]: iteration counter
//  - FSM: IDLE -> ADD -> SHIFT -> (ADD | DONE) -> IDLE.
//  - Reset (async, any state)
//    - state=IDLE; M, A, Q, C and cnt cleared.
//    - in_ready=1, out_valid=0, out_prod=0.
//    - ALU outputs at idle values.
//  - IDLE
//    - in_ready=1.
//    - On in_valid: M<=in_a, Q<=in_b, A<=0, C<=0, cnt<=0; go to ADD.
//  - ADD
//    - ALU driven: d1=A, d2=(Q[0] ? M : 0), carry_in=0, op=OP_ADD.
//    - Capture {C,A} <= {alu_carry_out, alu_res}; go to SHIFT.
//  - SHIFT
//    - ALU driven: d1=0, d2=A, carry_in=C, op=OP_RSHFT.
//    - A <= alu_res, i.e. {C, A[15:1]}; Q <= {A[0], Q[15:1]} (pre-shift A[0]).
//    - C <= 0; cnt <= cnt+1.
//    - If cnt==15 go to DONE, else go to ADD.
//  - DONE
//    - out_valid=1; out_prod={A,Q}, stable while waiting.
//    - On out_ready go to IDLE; a new operand is accepted no earlier than the next cycle.
//  - Idle ALU drive (IDLE/DONE): d1=d2=0, carry_in=0, op=OP_ADD.
//  - Outputs decode only from registers; no in_* -> out_* combinational path.
//  - alu_res/alu_carry_out are sampled only in ADD/SHIFT.
//  - Latency: accept at cycle 0 (IDLE, in_valid&in_ready).
//    - Cycles 1..32 alternate ADD/SHIFT.
//    - out_valid is first high in cycle 33.
//    - Latency is fixed and data-independent.
//  - in_valid outside IDLE: ignored; in_ready=0; operands not sampled.
//  - out_ready outside DONE: ignored.
//  - Carry: ADD carry-out must reach A[15] via the RSHFT carry_in in the next cycle.
//    - The 17-bit intermediate is never truncated.
//  - Reset mid-operation aborts immediately; no partial product is ever presented.
// TESTING
//  1. in_a=3, in_b=5 -> out_valid first high 33 cycles after accept; out_prod=32'h0000_000F.
//  2. in_a=16'hFFFF, in_b=16'hFFFF -> out_prod=32'hFFFE_0001 (exercises ADD carry into shift).
//  3. in_a=0, in_b=16'h1234, then in_a=16'h8000, in_b=2 -> 32'h0 then 32'h0001_0000.
//  4. out_ready low 5 cycles after out_valid -> out_prod/out_valid held, in_ready=0.
//     - in_valid pulsed during busy with in_a=7 is not captured; result is the original product.
//  5. rst asserted at cycle 10 of an operation -> same cycle: in_ready=1, out_valid=0.
//     - Next op in_a=100, in_b=200 -> out_prod=32'd20000.
//  6. Randomised 1000 operand pairs vs in_a*in_b reference.
//     - Check ALU op is OP_ADD in ADD and OP_RSHFT in SHIFT on every cycle.

Source files
------------

// File: rtl/alu16_mul_seq_if.sv
// Operand request / product return handshake bundle for alu16_mul_seq.
// The master is the requester; the slave is the sequencer.
interface alu16_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_prod
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_prod
  );
endinterface

// File: rtl/alu16_mul_seq.sv
// Unsigned 16x16->32 shift-and-add multiplier that borrows a shared
// 16-bit ALU for 16 ADD/RSHFT iteration pairs.
module alu16_mul_seq (
  input  logic                  clk,
  input  logic                  rst,
  alu16_mul_seq_if.slave        io,
  output logic [15:0]           alu_d1,
  output logic [15:0]           alu_d2,
  output logic                  alu_carry_in,
  output logic                  alu_carry_disable,
  output logic [1:0]            alu_cmd,
  input  logic [15:0]           alu_res,
  input  logic                  alu_carry_out
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_RSHFT = 3'b111;
  localparam int         ITER     = 16;
  localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [15:0] a_q, a_d;
  logic [15:0] q_q, q_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    a_d          = a_q;
    q_d          = q_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    op           = OP_ADD;
    alu_d1       = '0;
    alu_d2       = '0;
    alu_carry_in = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          m_d     = io.in_a;
          q_d     = io.in_b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        alu_d1     = a_q;
        alu_d2     = q_q[0] ? m_q : '0;
        {c_d, a_d} = {alu_carry_out, alu_res};
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        // carry from the add re-enters at A[15] through the shift
        alu_d2       = a_q;
        alu_carry_in = c_q;
        op           = OP_RSHFT;
        a_d          = alu_res;
        q_d          = {a_q[0], q_q[15:1]};
        c_d          = 1'b0;
        cnt_d        = cnt_q + 4'd1;
        state_d      = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        if (io.out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign {alu_carry_disable, alu_cmd} = op;

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.out_prod  = io.out_valid ? {a_q, q_q} : '0;

endmodule

// File: tb/tb_alu16_mul_seq.sv
// Scoreboard bench for alu16_mul_seq with a behavioural 16-bit ALU.
// Directed vectors plus random operands checked against a*b.
module tb_alu16_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_d1;
  logic [15:0] alu_d2;
  logic        alu_carry_in;
  logic        alu_carry_disable;
  logic [1:0]  alu_cmd;
  logic [15:0] alu_res;
  logic        alu_carry_out;

  alu16_mul_seq_if bus ();

  alu16_mul_seq dut (
    .clk               (clk),
    .rst               (rst),
    .io                (bus),
    .alu_d1            (alu_d1),
    .alu_d2            (alu_d2),
    .alu_carry_in      (alu_carry_in),
    .alu_carry_disable (alu_carry_disable),
    .alu_cmd           (alu_cmd),
    .alu_res           (alu_res),
    .alu_carry_out     (alu_carry_out)
  );

  always #5 clk = ~clk;

  // ALU model: ADD and RSHFT only
  always_comb begin
    alu_res       = '0;
    alu_carry_out = 1'b0;
    case ({alu_carry_disable, alu_cmd})
      3'b000: {alu_carry_out, alu_res} =
                {1'b0, alu_d1} + {1'b0, alu_d2} + {16'b0, alu_carry_in};
      3'b111: begin
        alu_res       = {alu_carry_in, alu_d2[15:1]};
        alu_carry_out = alu_d2[0];
      end
      default: ;
    endcase
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          phase = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: protocol, ALU drive and product checks
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (phase >= 1 && phase <= 32) begin
        chk(!bus.out_valid && !bus.in_ready, "busy_flags",
            {30'b0, bus.out_valid, bus.in_ready}, 32'h0);
        if (phase % 2 == 1)
          chk({alu_carry_disable, alu_cmd, alu_carry_in} == 4'b0000,
              "add_op", {28'b0, alu_carry_disable, alu_cmd, alu_carry_in},
              32'h0);
        else
          chk({alu_carry_disable, alu_cmd} == 3'b111, "shift_op",
              {29'b0, alu_carry_disable, alu_cmd}, 32'h7);
      end else begin
        chk({alu_carry_disable, alu_cmd, alu_carry_in} == 4'b0 &&
            alu_d1 == 16'h0 && alu_d2 == 16'h0, "idle_alu",
            {alu_d1, alu_d2}, 32'h0);
      end
      if (phase == 33)
        chk(bus.out_valid, "latency", {31'b0, bus.out_valid}, 32'h1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", bus.out_prod, 32'h0);
        end else begin
          chk(bus.out_prod == exp_q[0], "out_prod", bus.out_prod, exp_q[0]);
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          phase = 0;
        end
      end
      if (bus.in_valid && bus.in_ready)
        phase = 1;
      else if (phase >= 1 && phase < 33)
        phase++;
    end
  end

  // called at posedge+1; returns at posedge+1 after the accept edge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] e);
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) chk(1'b0, "in_ready_timeout", 32'h0, 32'h1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          w;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk(bus.in_ready && !bus.out_valid, "rst_flags",
        {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    chk(bus.out_prod == 32'h0, "rst_prod", bus.out_prod, 32'h0);
    chk({alu_d1, alu_d2} == 32'h0 && alu_carry_in == 1'b0 &&
        {alu_carry_disable, alu_cmd} == 3'b000, "rst_alu",
        {alu_d1, alu_d2}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed
    do_op(16'd3, 16'd5, 32'h0000_000F);
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    do_op(16'h0000, 16'h1234, 32'h0000_0000);
    do_op(16'h8000, 16'h0002, 32'h0001_0000);
    do_op(16'h0001, 16'hFFFF, 32'h0000_FFFF);

    // stall the consumer, poke in_valid while busy
    do_op(16'h0101, 16'h0101, 32'h0001_0201);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'd7;
    bus.in_b     = 16'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk(bus.out_valid, "stall_wait", {31'b0, bus.out_valid}, 32'h1);
    repeat (5) begin
      chk(!bus.in_ready, "stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;

    // abort mid-operation
    do_op(16'h00FF, 16'h00FF, 32'h0000_FE01);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(bus.in_ready && !bus.out_valid, "abort_flags",
        {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(16'd100, 16'd200, 32'd20000);

    // random operands
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, {16'b0, ra} * {16'b0, rb});
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
